rename_regfile: RTL and testbench
=================================

# rename_regfile

Parametrised architectural register file with per-register ROB rename tags for the out-of-order core. It sits between decode/dispatch and the reservation stations. For each dispatched source it returns either committed data or the ROB id that will produce it. It accepts up to COMMIT_WIDTH in-order commits per cycle from the ROB.

This generation generalises dispatch and commit width and register count. It takes explicit per-slot ROB ids, resolves intra-bundle dependencies for any slot count, and wakes up all registers on flush.

## Interface
Parameters:
- NUM_REGS, 32, architectural registers; register 0 is hardwired zero.
- DATA_WIDTH, 32, register data width.
- DISPATCH_WIDTH, 2, dispatch slots per cycle; slot 0 is oldest.
- COMMIT_WIDTH, 2, commit slots per cycle; slot 0 is oldest.
- ROB_ID_BITS, 5, ROB tag width.
- AW, $clog2(NUM_REGS), register address width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  branch mispredict; clears all pending tags.
- dispatch_valid  in  [DISPATCH_WIDTH]  slot k renames a destination this cycle.
- dispatch_rd  in  [DISPATCH_WIDTH][AW]  destination register for slot k.
- dispatch_rob_id  in  [DISPATCH_WIDTH][ROB_ID_BITS]  ROB id allocated to slot k.
- rs1_addr, rs2_addr  in  [DISPATCH_WIDTH][AW]  source addresses for slot k.
- rs1_data, rs2_data  out  [DISPATCH_WIDTH][DATA_WIDTH]  operand value; valid when ready=1.
- rs1_rob_id, rs2_rob_id  out  [DISPATCH_WIDTH][ROB_ID_BITS]  producer tag; valid when ready=0.
- rs1_ready, rs2_ready  out  [DISPATCH_WIDTH]  1 = use data, 0 = wait on tag.
- commit_valid  in  [COMMIT_WIDTH]  slot i commits a register result.
- commit_rd  in  [COMMIT_WIDTH][AW]  committed destination.
- commit_rob_id  in  [COMMIT_WIDTH][ROB_ID_BITS]  committing ROB id.
- commit_data  in  [COMMIT_WIDTH][DATA_WIDTH]  committed value.

## Operation
- State per register: data[DATA_WIDTH], tag[ROB_ID_BITS], ready.
- Reset: every entry gets data=0, tag=0, ready=1. Outputs are then combinational from this state.
- Register 0:
  - Dispatch and commit to rd=0 are ignored.
  - Reads of address 0 return data=0, ready=1, rob_id=0 regardless of other inputs.
- Read path (combinational), per slot j and per source, in priority order:
  - (a) Intra-bundle rename: among older slots k<j with dispatch_valid[k] and dispatch_rd[k]==addr, the highest such k wins. Return ready=0, rob_id=dispatch_rob_id[k], data=0. Slot j never sees its own destination.
  - (b) Commit bypass: stored ready=0, and some commit slot i has commit_valid[i], commit_rd[i]==addr and commit_rob_id[i]==stored tag. Return ready=1, data=commit_data[i]; highest matching i wins.
  - (c) Otherwise return the stored entry.
  - flush does not alter the read path in the same cycle.
- Data write: each valid commit writes data[commit_rd]. If several commit slots target one register, the highest index wins. Writes happen regardless of tag match and regardless of flush.
- Tag write: each valid dispatch writes tag[dispatch_rd]=dispatch_rob_id and ready=0. On same-register collisions, the highest slot wins.
- Ready set: a commit slot i sets ready[commit_rd[i]]=1 only when both hold:
  - commit_rob_id[i]==stored tag;
  - no valid dispatch targets that register this cycle.
  - Dispatch always wins over commit for ready and tag.
- Flush: all ready bits become 1. All dispatches in the flush cycle are dropped: no tag write, no ready clear. Commit data writes proceed.

## Timing
- Read latency 0 (combinational). Updates are visible on reads in the cycle after the edge.
- Commit data is visible to reads in the same cycle via bypass (b), and from the array the next cycle.
- No handshake and no back-pressure. The block accepts every valid slot every cycle.
- The ROB guarantees commit order (slot 0 oldest) and tag uniqueness among in-flight ids. A stale commit (tag mismatch) updates data only.
- rst has priority over flush, dispatch and commit. Reset mid-operation discards all pending tags in one cycle.

## Test plan
- Reset, then read x5 on both slots -> data=0, ready=1.
- Dispatch slot0 rd=x3 id=7, slot1 rs1=x3 in the same cycle -> slot1 rs1_ready=0, rs1_rob_id=7. Next cycle x3 reads tag 7, ready=0.
- x3 pending id 7; commit x3 id=7 data=0xDEADBEEF while slot0 reads x3 -> same-cycle ready=1, data=0xDEADBEEF. Next cycle the array holds the same.
- x3 pending id 9; commit x3 id=7 data=0x11 -> data updates to 0x11, ready stays 0, tag stays 9.
- Commit slot0 x4=0xA id=2 and slot1 x4=0xB id=3 with tag 3 -> x4=0xB, ready=1. Dispatch slot0 x4 id=5 and slot1 x4 id=6 -> tag=6.
- x1, x2, x3 pending; assert flush with a dispatch to x6 id=4 -> next cycle all ready=1, x6 tag unchanged. Dispatch or commit to x0 -> x0 reads 0, ready=1.

Source files
------------

// File: rtl/rename_regfile.sv
// Architectural register file with per-register ROB rename tags.
// Combinational operand read with intra-bundle rename and commit bypass; in-order commit writes.
module rename_regfile #(
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DISPATCH_WIDTH = 2,
    parameter int unsigned COMMIT_WIDTH   = 2,
    parameter int unsigned ROB_ID_BITS    = 5,
    parameter int unsigned AW             = $clog2(NUM_REGS)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         flush,
    input  logic [DISPATCH_WIDTH-1:0]                    dispatch_valid,
    input  logic [DISPATCH_WIDTH-1:0][AW-1:0]            dispatch_rd,
    input  logic [DISPATCH_WIDTH-1:0][ROB_ID_BITS-1:0]   dispatch_rob_id,
    input  logic [DISPATCH_WIDTH-1:0][AW-1:0]            rs1_addr,
    input  logic [DISPATCH_WIDTH-1:0][AW-1:0]            rs2_addr,
    output logic [DISPATCH_WIDTH-1:0][DATA_WIDTH-1:0]    rs1_data,
    output logic [DISPATCH_WIDTH-1:0][DATA_WIDTH-1:0]    rs2_data,
    output logic [DISPATCH_WIDTH-1:0][ROB_ID_BITS-1:0]   rs1_rob_id,
    output logic [DISPATCH_WIDTH-1:0][ROB_ID_BITS-1:0]   rs2_rob_id,
    output logic [DISPATCH_WIDTH-1:0]                    rs1_ready,
    output logic [DISPATCH_WIDTH-1:0]                    rs2_ready,
    input  logic [COMMIT_WIDTH-1:0]                      commit_valid,
    input  logic [COMMIT_WIDTH-1:0][AW-1:0]              commit_rd,
    input  logic [COMMIT_WIDTH-1:0][ROB_ID_BITS-1:0]     commit_rob_id,
    input  logic [COMMIT_WIDTH-1:0][DATA_WIDTH-1:0]      commit_data
);

    logic [DATA_WIDTH-1:0]  data_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]  data_d [NUM_REGS];
    logic [ROB_ID_BITS-1:0] tag_q  [NUM_REGS];
    logic [ROB_ID_BITS-1:0] tag_d  [NUM_REGS];
    logic [NUM_REGS-1:0]    ready_q;
    logic [NUM_REGS-1:0]    ready_d;
    logic [NUM_REGS-1:0]    disp_hit;

    logic [AW-1:0]          rd_addr;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic [ROB_ID_BITS-1:0] rd_tag;
    logic                   rd_rdy;

    // Read path: stored entry, overridden by commit bypass, overridden by older-slot rename.
    always_comb begin
        rs1_data   = '0;
        rs2_data   = '0;
        rs1_rob_id = '0;
        rs2_rob_id = '0;
        rs1_ready  = '0;
        rs2_ready  = '0;
        rd_addr    = '0;
        rd_data    = '0;
        rd_tag     = '0;
        rd_rdy     = 1'b1;
        for (int j = 0; j < int'(DISPATCH_WIDTH); j++) begin
            for (int s = 0; s < 2; s++) begin
                rd_addr = (s == 0) ? rs1_addr[j] : rs2_addr[j];
                rd_data = data_q[rd_addr];
                rd_tag  = tag_q[rd_addr];
                rd_rdy  = ready_q[rd_addr];
                if (!ready_q[rd_addr]) begin
                    for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
                        if (commit_valid[i] && commit_rd[i] == rd_addr &&
                            commit_rob_id[i] == tag_q[rd_addr]) begin
                            rd_rdy  = 1'b1;
                            rd_data = commit_data[i];
                        end
                    end
                end
                for (int k = 0; k < int'(DISPATCH_WIDTH); k++) begin
                    if (k < j && dispatch_valid[k] && dispatch_rd[k] == rd_addr) begin
                        rd_rdy  = 1'b0;
                        rd_tag  = dispatch_rob_id[k];
                        rd_data = '0;
                    end
                end
                if (rd_addr == '0) begin
                    rd_rdy  = 1'b1;
                    rd_tag  = '0;
                    rd_data = '0;
                end
                if (s == 0) begin
                    rs1_data[j]   = rd_data;
                    rs1_rob_id[j] = rd_tag;
                    rs1_ready[j]  = rd_rdy;
                end else begin
                    rs2_data[j]   = rd_data;
                    rs2_rob_id[j] = rd_tag;
                    rs2_ready[j]  = rd_rdy;
                end
            end
        end
    end

    always_comb begin
        data_d   = data_q;
        tag_d    = tag_q;
        ready_d  = ready_q;
        disp_hit = '0;
        for (int k = 0; k < int'(DISPATCH_WIDTH); k++) begin
            if (dispatch_valid[k] && dispatch_rd[k] != '0) begin
                disp_hit[dispatch_rd[k]] = 1'b1;
            end
        end
        // Ascending loops give the highest slot the final word.
        for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
            if (commit_valid[i] && commit_rd[i] != '0) begin
                data_d[commit_rd[i]] = commit_data[i];
                if (commit_rob_id[i] == tag_q[commit_rd[i]] && !disp_hit[commit_rd[i]]) begin
                    ready_d[commit_rd[i]] = 1'b1;
                end
            end
        end
        if (flush) begin
            ready_d = '1;
        end else begin
            for (int k = 0; k < int'(DISPATCH_WIDTH); k++) begin
                if (dispatch_valid[k] && dispatch_rd[k] != '0) begin
                    tag_d[dispatch_rd[k]]   = dispatch_rob_id[k];
                    ready_d[dispatch_rd[k]] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            ready_q <= '1;
        end else begin
            data_q  <= data_d;
            tag_q   <= tag_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: the driver queues expected operand reads,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rename_regfile;
    localparam int DW = 2;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic [DW-1:0]        dispatch_valid;
    logic [DW-1:0][4:0]   dispatch_rd;
    logic [DW-1:0][4:0]   dispatch_rob_id;
    logic [DW-1:0][4:0]   rs1_addr;
    logic [DW-1:0][4:0]   rs2_addr;
    logic [DW-1:0][31:0]  rs1_data;
    logic [DW-1:0][31:0]  rs2_data;
    logic [DW-1:0][4:0]   rs1_rob_id;
    logic [DW-1:0][4:0]   rs2_rob_id;
    logic [DW-1:0]        rs1_ready;
    logic [DW-1:0]        rs2_ready;
    logic [CW-1:0]        commit_valid;
    logic [CW-1:0][4:0]   commit_rd;
    logic [CW-1:0][4:0]   commit_rob_id;
    logic [CW-1:0][31:0]  commit_data;

    rename_regfile dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_rd(dispatch_rd),
        .dispatch_rob_id(dispatch_rob_id),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_rob_id(rs1_rob_id), .rs2_rob_id(rs2_rob_id),
        .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_rob_id(commit_rob_id), .commit_data(commit_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        int          slot;
        int          src;
        logic        rdy;
        logic [31:0] data;
        logic [4:0]  tag;
        bit          chk_data;
        bit          chk_tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_exp = 0;

    task automatic idle();
        flush = 1'b0;
        dispatch_valid = '0; dispatch_rd = '0; dispatch_rob_id = '0;
        rs1_addr = '0; rs2_addr = '0;
        commit_valid = '0; commit_rd = '0; commit_rob_id = '0; commit_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic push(input int slot, input int src, input logic rdy, input logic [31:0] d,
                        input logic [4:0] t, input bit cd, input bit ct);
        exp_t e;
        e.id = n_exp; e.slot = slot; e.src = src; e.rdy = rdy; e.data = d; e.tag = t;
        e.chk_data = cd; e.chk_tag = ct;
        n_exp++;
        exp_q.push_back(e);
    endtask

    task automatic exp_ready(input int slot, input int src, input logic [31:0] d);
        push(slot, src, 1'b1, d, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic exp_wait(input int slot, input int src, input logic [4:0] t);
        push(slot, src, 1'b0, 32'd0, t, 1'b0, 1'b1);
    endtask

    task automatic disp(input int slot, input logic [4:0] rd, input logic [4:0] id);
        dispatch_valid[slot] = 1'b1; dispatch_rd[slot] = rd; dispatch_rob_id[slot] = id;
    endtask

    task automatic cmt(input int slot, input logic [4:0] rd, input logic [4:0] id,
                       input logic [31:0] d);
        commit_valid[slot] = 1'b1; commit_rd[slot] = rd;
        commit_rob_id[slot] = id; commit_data[slot] = d;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic        a_rdy;
            logic [31:0] a_data;
            logic [4:0]  a_tag;
            e = exp_q.pop_front();
            a_rdy  = (e.src == 0) ? rs1_ready[e.slot]  : rs2_ready[e.slot];
            a_data = (e.src == 0) ? rs1_data[e.slot]   : rs2_data[e.slot];
            a_tag  = (e.src == 0) ? rs1_rob_id[e.slot] : rs2_rob_id[e.slot];
            total++;
            if (a_rdy !== e.rdy || (e.chk_data && a_data !== e.data) ||
                (e.chk_tag && a_tag !== e.tag)) begin
                bad++;
                $display("FAIL chk%0d slot%0d rs%0d: got rdy=%b data=%h tag=%0d, want rdy=%b data=%h tag=%0d",
                         e.id, e.slot, e.src + 1, a_rdy, a_data, a_tag, e.rdy, e.data, e.tag);
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state: x5 on both slots.
        rs1_addr[0] = 5'd5; rs1_addr[1] = 5'd5; rs2_addr[1] = 5'd5;
        exp_ready(0, 0, 32'd0); exp_ready(1, 0, 32'd0); exp_ready(1, 1, 32'd0);
        tick();
        // Intra-bundle rename; slot 0 does not see its own destination.
        disp(0, 5'd3, 5'd7); rs1_addr[1] = 5'd3; rs1_addr[0] = 5'd3;
        exp_wait(1, 0, 5'd7); push(1, 0, 1'b0, 32'd0, 5'd7, 1'b1, 1'b1);
        exp_ready(0, 0, 32'd0);
        tick();
        rs1_addr[0] = 5'd3; exp_wait(0, 0, 5'd7);
        tick();
        // Same-cycle commit bypass.
        cmt(0, 5'd3, 5'd7, 32'hDEADBEEF); rs1_addr[0] = 5'd3;
        exp_ready(0, 0, 32'hDEADBEEF);
        tick();
        rs1_addr[0] = 5'd3; exp_ready(0, 0, 32'hDEADBEEF);
        tick();
        // Stale commit updates data only.
        disp(0, 5'd3, 5'd9);
        tick();
        cmt(0, 5'd3, 5'd7, 32'h11); rs1_addr[0] = 5'd3;
        exp_wait(0, 0, 5'd9);
        tick();
        rs1_addr[0] = 5'd3; push(0, 0, 1'b0, 32'h11, 5'd9, 1'b1, 1'b1);
        tick();
        // Two commits to x4, highest slot wins.
        disp(0, 5'd4, 5'd3);
        tick();
        cmt(0, 5'd4, 5'd2, 32'hA); cmt(1, 5'd4, 5'd3, 32'hB); rs1_addr[0] = 5'd4;
        exp_ready(0, 0, 32'hB);
        tick();
        rs1_addr[0] = 5'd4; exp_ready(0, 0, 32'hB);
        tick();
        disp(0, 5'd4, 5'd5); disp(1, 5'd4, 5'd6); rs2_addr[1] = 5'd4;
        exp_wait(1, 1, 5'd5);
        tick();
        rs1_addr[0] = 5'd4; exp_wait(0, 0, 5'd6);
        tick();
        // Flush wakes everything and drops the dispatch to x6.
        disp(0, 5'd1, 5'd10); disp(1, 5'd2, 5'd11);
        tick();
        flush = 1'b1; disp(0, 5'd6, 5'd4);
        rs1_addr[0] = 5'd1; rs2_addr[0] = 5'd2; rs1_addr[1] = 5'd1;
        exp_wait(0, 0, 5'd10); exp_wait(0, 1, 5'd11); exp_wait(1, 0, 5'd10);
        tick();
        rs1_addr[0] = 5'd1; rs2_addr[0] = 5'd2; rs1_addr[1] = 5'd3; rs2_addr[1] = 5'd6;
        exp_ready(0, 0, 32'd0); exp_ready(0, 1, 32'd0); exp_ready(1, 0, 32'h11);
        push(1, 1, 1'b1, 32'd0, 5'd0, 1'b1, 1'b1);
        tick();
        // Dispatch beats a matching commit for ready and tag.
        disp(0, 5'd7, 5'd13);
        tick();
        cmt(0, 5'd7, 5'd13, 32'h77); disp(1, 5'd7, 5'd14); rs1_addr[0] = 5'd7;
        exp_ready(0, 0, 32'h77);
        tick();
        rs1_addr[0] = 5'd7; push(0, 0, 1'b0, 32'h77, 5'd14, 1'b1, 1'b1);
        tick();
        // Register 0 ignores dispatch and commit.
        disp(0, 5'd0, 5'd15); cmt(0, 5'd0, 5'd0, 32'h55); rs1_addr[1] = 5'd0;
        push(1, 0, 1'b1, 32'd0, 5'd0, 1'b1, 1'b1);
        tick();
        rs1_addr[0] = 5'd0; rs2_addr[1] = 5'd0;
        push(0, 0, 1'b1, 32'd0, 5'd0, 1'b1, 1'b1); push(1, 1, 1'b1, 32'd0, 5'd0, 1'b1, 1'b1);
        tick();
        // Mid-operation reset discards x7's pending tag.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rs1_addr[0] = 5'd7; push(0, 0, 1'b1, 32'd0, 5'd0, 1'b1, 1'b1);
        tick();
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
